dot_product_top: RTL and testbench
==================================

// Module: dot_product_top
// PURPOSE
//   Dot-product engine top level. Holds two operand vectors in on-chip RAMs A/B.
//   On start, a reader FSM computes sum(A[i]*B[i]) for i=0..VECTOR_WIDTH-1.
//   A writer FSM then stores the result in a result RAM at an auto-incrementing slot.
//   Results are read back via a read port. Sits between the host load/readback bus and the MAC datapath.
// PARAMETERS
//   DATA_WIDTH      8    operand width and result-RAM word width
//   VECTOR_WIDTH    4    elements per dot product (read from addresses 0..VECTOR_WIDTH-1)
//   DEPTH           32   entries in each operand RAM (VECTOR_WIDTH*DATA_WIDTH)
//   ADDR_WIDTH      5    operand RAM address width
//   RESULT_WIDTH    18   accumulator width (2*DATA_WIDTH+$clog2(VECTOR_WIDTH))
//   MEM3_ADDR_WIDTH 4    result RAM address width (read_addr, write pointer)
//   MEM3_SIZE       64   result RAM entries declared; only 2**MEM3_ADDR_WIDTH are addressable
// PORTS
//   clk            in   1             single clock, all state on rising edge
//   rst_n          in   1             asynchronous active-low reset
//   write_en       in   1             operand write strobe
//   write_addr     in   ADDR_WIDTH    operand RAM write address
//   data_a         in   DATA_WIDTH    word written to RAM A
//   data_b         in   DATA_WIDTH    word written to RAM B
//   start_reading  in   1             1-cycle pulse starting a dot product
//   reading_done   out  1             accumulation complete (level)
//   read_en        in   1             result read strobe
//   read_addr      in   MEM3_ADDR_WIDTH  result RAM read address
//   result_out     out  DATA_WIDTH    result RAM read data
//   writer_busy    out  1             writer storing the result
//   writer_done    out  1             result stored (level)
// BEHAVIOUR
// - Reset (async, rst_n=0):
//   - Both FSMs go to IDLE. Accumulator=0. Write pointer=0.
//   - reading_done=0, writer_busy=0, writer_done=0. Result RAM cleared to 0.
//   - Operand RAMs are not reset.
//   - Reset mid-operation aborts the operation; nothing is written.
// - Operand load:
//   - When write_en=1 at a rising edge: A[write_addr]<=data_a and B[write_addr]<=data_b.
//   - Writes are accepted in every state.
// - Reader FSM: IDLE -> READ -> ACC -> DONE.
//   - IDLE: start_reading=1 clears the accumulator and the index, clears reading_done and
//     writer_done, then moves to READ.
//   - READ: issue synchronous reads of A[idx] and B[idx] for idx=0..VECTOR_WIDTH-1, one per cycle.
//     Products are accumulated one cycle later, unsigned, at RESULT_WIDTH with no overflow possible.
//   - ACC: drains the last product.
//   - DONE: sets reading_done=1, pulses an internal request to the writer, returns to IDLE.
//   - reading_done=1 is reached within VECTOR_WIDTH+3 cycles of start and holds until the next
//     accepted start or reset.
//   - start_reading is ignored unless both FSMs are IDLE.
// - Writer FSM: IDLE -> WRITE -> DONE.
//   - IDLE: a request moves it to WRITE.
//   - WRITE, one cycle, writer_busy=1: mem3[wr_ptr]<=acc[DATA_WIDTH-1:0] (truncated);
//     wr_ptr<=wr_ptr+1, wrapping modulo 2**MEM3_ADDR_WIDTH.
//   - DONE: writer_done=1, writer_busy=0; returns to IDLE. writer_done holds until the next
//     accepted start or reset.
// - Readback:
//   - result_out = mem3[read_addr], asynchronous read.
//   - read_en has no effect on data; it is kept for bus compatibility.
//   - Reading an unwritten slot returns 0.
//   - If read_addr equals wr_ptr during WRITE, result_out shows the old value until the edge.
// - Operand writes during READ are permitted; each element uses the value present in the RAM
//   on the cycle it is read.
// TESTING
//   - Load A={1,2,3,4}, B={1,1,1,1}, pulse start -> reading_done, then writer_done; mem3[0]=10.
//   - Then load A={2,4,6,8}, B={1,2,3,4}, pulse start -> mem3[1]=60; mem3[0] still 10.
//   - Then load A={0,5,0,3}, B={2,0,4,1}, pulse start -> mem3[2]=3.
//   - Load A=B={255,255,255,255} -> acc=260100; stored 260100 mod 256=4.
//     Run 17 starts -> wr_ptr wraps and slot 0 is overwritten.
//   - Pulse start while busy -> ignored, one result written.
//     Assert rst_n=0 mid-READ -> all outputs 0, wr_ptr=0, mem3 reads 0.
//   - writer_busy is high for exactly one cycle per result.
//     reading_done and writer_done stay high until the next start.

Source files
------------

// File: rtl/dot_product_top.sv
// Dot-product engine: operand RAMs A/B, a reader FSM that accumulates sum(A[i]*B[i]),
// and a writer FSM that stores each truncated result in an auto-incrementing result RAM.
module dot_product_top #(
    parameter int DATA_WIDTH      = 8,
    parameter int VECTOR_WIDTH    = 4,
    parameter int DEPTH           = 32,
    parameter int ADDR_WIDTH      = 5,
    parameter int RESULT_WIDTH    = 18,
    parameter int MEM3_ADDR_WIDTH = 4,
    parameter int MEM3_SIZE       = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       write_en,
    input  logic [ADDR_WIDTH-1:0]      write_addr,
    input  logic [DATA_WIDTH-1:0]      data_a,
    input  logic [DATA_WIDTH-1:0]      data_b,
    input  logic                       start_reading,
    output logic                       reading_done,
    input  logic                       read_en,
    input  logic [MEM3_ADDR_WIDTH-1:0] read_addr,
    output logic [DATA_WIDTH-1:0]      result_out,
    output logic                       writer_busy,
    output logic                       writer_done
);

    localparam logic [1:0] RD_IDLE  = 2'd0;
    localparam logic [1:0] RD_READ  = 2'd1;
    localparam logic [1:0] RD_ACC   = 2'd2;
    localparam logic [1:0] RD_DONE  = 2'd3;

    localparam logic [1:0] WR_IDLE  = 2'd0;
    localparam logic [1:0] WR_WRITE = 2'd1;
    localparam logic [1:0] WR_DONE  = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(VECTOR_WIDTH - 1);

    logic [DATA_WIDTH-1:0]      r_mem_a [DEPTH];
    logic [DATA_WIDTH-1:0]      r_mem_b [DEPTH];
    logic [DATA_WIDTH-1:0]      r_mem3  [MEM3_SIZE];

    logic [1:0]                 r_rd_state;
    logic [1:0]                 r_wr_state;
    logic [ADDR_WIDTH-1:0]      r_idx;
    logic [DATA_WIDTH-1:0]      r_a_q;
    logic [DATA_WIDTH-1:0]      r_b_q;
    logic                       r_prod_valid;
    logic [RESULT_WIDTH-1:0]    r_acc;
    logic                       r_reading_done;
    logic                       r_req;
    logic [MEM3_ADDR_WIDTH-1:0] r_wr_ptr;
    logic                       r_writer_done;

    logic                       w_start_ok;
    logic [2*DATA_WIDTH-1:0]    w_product;
    logic [RESULT_WIDTH-1:0]    w_product_ext;
    logic                       w_unused;

    // A start is only honoured when neither FSM has work in flight, including a pending request.
    assign w_start_ok    = start_reading && (r_rd_state == RD_IDLE) &&
                           (r_wr_state == WR_IDLE) && !r_req;
    assign w_product     = r_a_q * r_b_q;
    assign w_product_ext = {{(RESULT_WIDTH-2*DATA_WIDTH){1'b0}}, w_product};
    assign w_unused      = read_en;

    always_ff @(posedge clk) begin
        if (write_en) begin
            r_mem_a[write_addr] <= data_a;
            r_mem_b[write_addr] <= data_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_state     <= RD_IDLE;
            r_idx          <= '0;
            r_a_q          <= '0;
            r_b_q          <= '0;
            r_prod_valid   <= 1'b0;
            r_acc          <= '0;
            r_reading_done <= 1'b0;
            r_req          <= 1'b0;
        end else begin
            r_req        <= 1'b0;
            r_prod_valid <= 1'b0;
            // Operands registered in READ are multiplied and summed on the following cycle.
            if (r_prod_valid) begin
                r_acc <= r_acc + w_product_ext;
            end
            case (r_rd_state)
                RD_IDLE: begin
                    if (w_start_ok) begin
                        r_acc          <= '0;
                        r_idx          <= '0;
                        r_reading_done <= 1'b0;
                        r_rd_state     <= RD_READ;
                    end
                end
                RD_READ: begin
                    r_a_q        <= r_mem_a[r_idx];
                    r_b_q        <= r_mem_b[r_idx];
                    r_prod_valid <= 1'b1;
                    r_idx        <= r_idx + 1'b1;
                    if (r_idx == LAST_IDX) begin
                        r_rd_state <= RD_ACC;
                    end
                end
                RD_ACC: begin
                    r_rd_state <= RD_DONE;
                end
                RD_DONE: begin
                    r_reading_done <= 1'b1;
                    r_req          <= 1'b1;
                    r_rd_state     <= RD_IDLE;
                end
                default: begin
                    r_rd_state <= RD_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_state    <= WR_IDLE;
            r_wr_ptr      <= '0;
            r_writer_done <= 1'b0;
            for (int i = 0; i < MEM3_SIZE; i++) begin
                r_mem3[i] <= '0;
            end
        end else begin
            case (r_wr_state)
                WR_IDLE: begin
                    if (w_start_ok) begin
                        r_writer_done <= 1'b0;
                    end
                    if (r_req) begin
                        r_wr_state <= WR_WRITE;
                    end
                end
                WR_WRITE: begin
                    r_mem3[r_wr_ptr] <= r_acc[DATA_WIDTH-1:0];
                    r_wr_ptr         <= r_wr_ptr + 1'b1;
                    r_wr_state       <= WR_DONE;
                end
                WR_DONE: begin
                    r_writer_done <= 1'b1;
                    r_wr_state    <= WR_IDLE;
                end
                default: begin
                    r_wr_state <= WR_IDLE;
                end
            endcase
        end
    end

    assign reading_done = r_reading_done;
    assign writer_done  = r_writer_done;
    assign writer_busy  = (r_wr_state == WR_WRITE);
    assign result_out   = r_mem3[read_addr];

endmodule

// File: tb/tb_dot_product_top.sv
// Scoreboard bench for dot_product_top: stimulus pushes the expected {slot, value} of each
// dot product; a monitor pops and checks it when writer_done rises.
module tb_dot_product_top;

    typedef struct packed {
        logic [3:0] slot;
        logic [7:0] value;
    } expT;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       write_en;
    logic [4:0] write_addr;
    logic [7:0] data_a;
    logic [7:0] data_b;
    logic       start_reading;
    logic       reading_done;
    logic       read_en;
    logic [3:0] read_addr;
    logic [7:0] result_out;
    logic       writer_busy;
    logic       writer_done;

    int  compareCount = 0;
    int  failCount    = 0;
    int  expPtr       = 0;
    expT sbQueue[$];

    dot_product_top dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .write_en     (write_en),
        .write_addr   (write_addr),
        .data_a       (data_a),
        .data_b       (data_b),
        .start_reading(start_reading),
        .reading_done (reading_done),
        .read_en      (read_en),
        .read_addr    (read_addr),
        .result_out   (result_out),
        .writer_busy  (writer_busy),
        .writer_done  (writer_done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic loadVectors(input logic [31:0] a, input logic [31:0] b);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            write_en   = 1'b1;
            write_addr = 5'(i);
            data_a     = a[8*i +: 8];
            data_b     = b[8*i +: 8];
        end
        @(posedge clk);
        #1;
        write_en = 1'b0;
    endtask

    task automatic readSlot(input logic [3:0] slot, input logic [7:0] expected);
        @(negedge clk);
        read_addr = slot;
        #1;
        checkOutput($sformatf("slot%0d", slot), {24'b0, result_out}, {24'b0, expected});
    endtask

    // Loads operands, queues the expected result and runs one dot product to writer_done.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic [7:0] expVal, input int extraStartAt);
        int  readLat;
        bit  gotDone;
        loadVectors(a, b);
        sbQueue.push_back('{slot: 4'(expPtr), value: expVal});
        expPtr = (expPtr + 1) % 16;
        @(posedge clk);
        #1 start_reading = 1'b1;
        @(posedge clk);
        #1 start_reading = 1'b0;
        readLat = 0;
        gotDone = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) begin
                checkOutput("doneCleared", {30'b0, reading_done, writer_done}, 32'd0);
            end
            if (reading_done && readLat == 0) begin
                readLat = n;
            end
            start_reading = (n == extraStartAt);
            if (writer_done) begin
                gotDone = 1'b1;
                break;
            end
        end
        start_reading = 1'b0;
        checkOutput("readLatencyWithinBound", {31'b0, (readLat >= 1 && readLat <= 7)}, 32'd1);
        checkOutput("writerDoneSeen", {31'b0, gotDone}, 32'd1);
    endtask

    // Monitor: each rising writer_done pops one expected result and reads its slot back.
    initial begin
        bit  prevDone;
        int  busyCount;
        expT item;
        prevDone  = 1'b0;
        busyCount = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prevDone  = 1'b0;
                busyCount = 0;
                continue;
            end
            if (writer_busy) begin
                busyCount++;
            end
            if (writer_done && !prevDone) begin
                if (sbQueue.size() == 0) begin
                    compareCount++;
                    failCount++;
                    $display("[TB] FAIL unexpectedResult: got a stored result, expected none queued");
                end else begin
                    item      = sbQueue.pop_front();
                    read_addr = item.slot;
                    #1;
                    checkOutput($sformatf("result@slot%0d", item.slot), {24'b0, result_out}, {24'b0, item.value});
                    checkOutput("busyPulseCycles", busyCount, 32'd1);
                end
                busyCount = 0;
            end
            prevDone = writer_done;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n         = 1'b0;
        write_en      = 1'b0;
        write_addr    = '0;
        data_a        = '0;
        data_b        = '0;
        start_reading = 1'b0;
        read_en       = 1'b1;
        read_addr     = '0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetReadingDone", {31'b0, reading_done}, 32'd0);
        checkOutput("resetWriterBusy",  {31'b0, writer_busy},  32'd0);
        checkOutput("resetWriterDone",  {31'b0, writer_done},  32'd0);
        checkOutput("resetResultOut",   {24'b0, result_out},   32'd0);
        rst_n = 1'b1;
        readSlot(4'd15, 8'd0);

        $display("[TB] basic dot products");
        applyStimulus(32'h04030201, 32'h01010101, 8'd10, 0);
        readSlot(4'd1, 8'd0);
        applyStimulus(32'h08060402, 32'h04030201, 8'd60, 0);
        readSlot(4'd0, 8'd10);
        applyStimulus(32'h03000500, 32'h01040002, 8'd3, 0);
        applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 8'd4, 0);

        $display("[TB] pointer wrap");
        for (int k = 0; k < 17; k++) begin
            applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 8'd4, 0);
        end
        readSlot(4'd0, 8'd4);
        readSlot(4'd3, 8'd4);

        $display("[TB] start while busy");
        applyStimulus(32'h01010101, 32'h05030201, 8'd11, 3);
        repeat (5) @(negedge clk);
        checkOutput("doneLevelsHold", {30'b0, reading_done, writer_done}, 32'd3);
        applyStimulus(32'h00000003, 32'h00000007, 8'd21, 8);
        readSlot(4'd5, 8'd11);
        readSlot(4'd7, 8'd4);

        $display("[TB] reset mid-read");
        loadVectors(32'h04030201, 32'h01010101);
        @(posedge clk);
        #1 start_reading = 1'b1;
        @(posedge clk);
        #1 start_reading = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abortReadingDone", {31'b0, reading_done}, 32'd0);
        checkOutput("abortWriterBusy",  {31'b0, writer_busy},  32'd0);
        checkOutput("abortWriterDone",  {31'b0, writer_done},  32'd0);
        readSlot(4'd0, 8'd0);
        readSlot(4'd5, 8'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        expPtr = 0;
        applyStimulus(32'h04030201, 32'h01010101, 8'd10, 0);
        readSlot(4'd0, 8'd10);
        readSlot(4'd1, 8'd0);

        repeat (3) @(negedge clk);
        checkOutput("scoreboardEmpty", sbQueue.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
